// File: rtl/had_div32.sv
// had_div32 - 32-lane element-wise divider for signed Q7.24 operands:
// z[i] = x[i] / y[i]. A single shared radix-2 restoring divider works
// through the lanes one after another, producing one quotient bit per cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (x, y captured on accept)
//   x, y   [1023:0]      dividends / divisors, lane 0 in [1023:992]
//   out_valid/out_ready  result handshake
//   z      [1023:0]      quotients, same packing as x
//   div0   [31:0]        bit i set when lane i had a zero divisor
//
// Build option: define HAD_DIV_SAT_EN to saturate out-of-range quotients;
// without it z[i] keeps the low 32 bits of the signed quotient.
//
// state   | meaning
// S_IDLE  | waiting for operands, in_ready=1
// S_LOAD  | form magnitudes and sign of the current lane
// S_ITER  | 56 restoring-division steps, MSB first
// S_STORE | write lane quotient and flag, advance lane
// S_DONE  | result valid, waiting for out_ready
module had_div32 (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] x,
    input  logic [1023:0] y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1023:0] z,
    output logic [31:0]   div0
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_STORE, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [1023:0] x_reg, y_reg;
    logic [4:0]    lane;
    logic [5:0]    cnt;
    logic [31:0]   rem;
    logic [55:0]   dvd;     // dividend bits shift out, quotient bits shift in
    logic [31:0]   dy;
    logic          sgn, xneg, zdiv;

    logic          accept;
    logic [9:0]    lane_base;
    logic [31:0]   x_lane, y_lane, ax, ay;
    logic [32:0]   rem_sh, diff;
    logic          ge;
    logic [31:0]   res;

    assign accept    = in_valid && in_ready;
    // lane 0 occupies the top word, so the base offset is (31 - lane) * 32
    assign lane_base = {~lane, 5'b0};
    assign x_lane    = x_reg[lane_base +: 32];
    assign y_lane    = y_reg[lane_base +: 32];
    // -2^31 negates to itself, which reads correctly as unsigned 2^31
    assign ax        = x_lane[31] ? (~x_lane + 32'd1) : x_lane;
    assign ay        = y_lane[31] ? (~y_lane + 32'd1) : y_lane;

    assign rem_sh    = {rem, dvd[55]};
    assign diff      = rem_sh - {1'b0, dy};
    assign ge        = ~diff[32];

    always_comb begin
        res = sgn ? (~dvd[31:0] + 32'd1) : dvd[31:0];
`ifdef HAD_DIV_SAT_EN
        if (!sgn && (dvd > 56'h0000_0000_7FFF_FFFF))
            res = 32'h7FFF_FFFF;
        else if (sgn && (dvd > 56'h0000_0000_8000_0000))
            res = 32'h8000_0000;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = (y_lane == 32'd0) ? S_STORE : S_ITER;
            S_ITER:  if (cnt == 6'd55) state_nxt = S_STORE;
            S_STORE: state_nxt = (lane == 5'd31) ? S_DONE : S_LOAD;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
            lane  <= '0;
            cnt   <= '0;
            rem   <= '0;
            dvd   <= '0;
            dy    <= '0;
            sgn   <= 1'b0;
            xneg  <= 1'b0;
            zdiv  <= 1'b0;
            z     <= '0;
            div0  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        x_reg <= x;
                        y_reg <= y;
                        lane  <= '0;
                        div0  <= '0;
                    end
                end
                S_LOAD: begin
                    dvd  <= {ax, 24'b0};
                    dy   <= ay;
                    rem  <= '0;
                    cnt  <= '0;
                    sgn  <= x_lane[31] ^ y_lane[31];
                    xneg <= x_lane[31];
                    zdiv <= (ay == 32'd0);
                end
                S_ITER: begin
                    rem <= ge ? diff[31:0] : rem_sh[31:0];
                    dvd <= {dvd[54:0], ge};
                    cnt <= cnt + 6'd1;
                end
                S_STORE: begin
                    if (zdiv) begin
                        z[lane_base +: 32] <= xneg ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        div0[lane]         <= 1'b1;
                    end else begin
                        z[lane_base +: 32] <= res;
                    end
                    lane <= lane + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
